// File: rtl/alu_pkg.sv
// Shared constants for the pipelined ALU: operation codes, status bit positions and opcode width.
package alu_pkg;

  localparam int ALUOP_W = 3;

  localparam logic [ALUOP_W-1:0] OP_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] OP_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] OP_AND = 3'b010;
  localparam logic [ALUOP_W-1:0] OP_NOT = 3'b011;
  localparam logic [ALUOP_W-1:0] OP_OR  = 3'b100;
  localparam logic [ALUOP_W-1:0] OP_XOR = 3'b101;
  localparam logic [ALUOP_W-1:0] OP_SHL = 3'b110;
  localparam logic [ALUOP_W-1:0] OP_SHR = 3'b111;

  localparam int ST_Z = 2;
  localparam int ST_N = 1;
  localparam int ST_V = 0;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between the register-file read stage, alu_pipe and writeback.
interface alu_pipe_if #(parameter int WIDTH = 16);

  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            Ain;
  logic [WIDTH-1:0]            Bin;
  logic [alu_pkg::ALUOP_W-1:0] ALUop;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out;
  logic                        Z;
  logic                        N;
  logic                        V;
  logic [2:0]                  status;

  modport master (
    output in_valid, Ain, Bin, ALUop, out_ready,
    input  in_ready, out_valid, out, Z, N, V, status
  );

  modport slave (
    input  in_valid, Ain, Bin, ALUop, out_ready,
    output in_ready, out_valid, out, Z, N, V, status
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath with Z/N/V flags; shifts on 110/111 only when ALU_SHIFT_EN is defined,
// otherwise those codes pass Bin through.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [ALUOP_W-1:0] op,
  output logic [WIDTH-1:0]   result,
  output logic               z,
  output logic               n,
  output logic               v
);

  localparam int MSB = WIDTH - 1;
`ifdef ALU_SHIFT_EN
  localparam int SH_W = $clog2(WIDTH);
`endif

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    // NOTE: defaults first so no path through the case can leave an output unassigned (latch).
    result = '0;
    v      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        v      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result = diff;
        v      = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_NOT: result = ~b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
`ifdef ALU_SHIFT_EN
      OP_SHL: result = a << b[SH_W-1:0];
      OP_SHR: result = $unsigned($signed(a) >>> b[SH_W-1:0]);
`else
      OP_SHL, OP_SHR: result = b;
`endif
    endcase
  end

  assign z = (result == '0);
  assign n = result[MSB];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with sticky {Z,N,V} status of the last consumed result.
// Optional shifter selected by the ALU_SHIFT_EN macro (see alu_core).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [ALUOP_W-1:0] s1_op;

  logic               s2_valid;
  logic [WIDTH-1:0]   s2_out;
  logic               s2_z;
  logic               s2_n;
  logic               s2_v;
  logic [2:0]         status_q;

  logic [WIDTH-1:0]   res;
  logic               res_z;
  logic               res_n;
  logic               res_v;

  logic               adv;
  logic               in_ready;
  logic               take;
  logic               drain;

  // Both stages move together; stage 1 frees up whenever stage 2 can accept.
  assign adv      = !s2_valid || bus.out_ready;
  assign in_ready = !s1_valid || adv;
  assign take     = bus.in_valid && in_ready;
  assign drain    = s2_valid && bus.out_ready;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else if (in_ready) s1_valid <= bus.in_valid;
  end

  // NOTE: operand registers carry no reset; they are qualified by s1_valid, which is reset.
  always_ff @(posedge clk) begin
    if (take) begin
      s1_a  <= bus.Ain;
      s1_b  <= bus.Bin;
      s1_op <= bus.ALUop;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (res),
    .z      (res_z),
    .n      (res_n),
    .v      (res_v)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_z     <= 1'b0;
      s2_n     <= 1'b0;
      s2_v     <= 1'b0;
      status_q <= '0;
    end else begin
      if (adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_out <= res;
          s2_z   <= res_z;
          s2_n   <= res_n;
          s2_v   <= res_v;
        end
      end
      if (drain) begin
        status_q[ST_Z] <= s2_z;
        status_q[ST_N] <= s2_n;
        status_q[ST_V] <= s2_v;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out       = s2_out;
  assign bus.Z         = s2_z;
  assign bus.N         = s2_n;
  assign bus.V         = s2_v;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=16, with WIDTH=8 and WIDTH=32 instances for the basic ops.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(16)) bus16 ();
  alu_pipe_if #(.WIDTH(8))  bus8  ();
  alu_pipe_if #(.WIDTH(32)) bus32 ();

  alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
  alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

  int checks = 0;
  int passed = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one item on the 16-bit DUT with the consumer ready; returns out_valid seen one cycle after accept.
  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         output logic ov_early);
    bus16.out_ready = 1'b1;
    bus16.Ain       = a;
    bus16.Bin       = b;
    bus16.ALUop     = op;
    bus16.in_valid  = 1'b1;
    step();
    bus16.in_valid  = 1'b0;
    ov_early        = bus16.out_valid;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.Ain = '0; bus16.Bin = '0; bus16.ALUop = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1; bus8.Ain = '0; bus8.Bin = '0; bus8.ALUop = '0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.Ain = '0; bus32.Bin = '0; bus32.ALUop = '0;
    step();
    step();
    reset = 1'b0;
    checks++; if (bus16.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus16.out_valid); else passed++;
    checks++; if (bus16.out !== 16'h0000) $display("FAIL reset_out got=%h exp=0000", bus16.out); else passed++;
    checks++; if (bus16.status !== 3'b000) $display("FAIL reset_status got=%b exp=000", bus16.status); else passed++;
    checks++; if (bus16.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus16.in_ready); else passed++;
    checks++; if ({bus16.Z, bus16.N, bus16.V} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {bus16.Z, bus16.N, bus16.V}); else passed++;
  endtask

  task automatic test_basic_ops();
    logic [15:0] exp_out [4];
    logic        exp_n   [4];
    logic        ov_early;
    exp_out = '{16'h0013, 16'h0007, 16'h0004, 16'hFFF9};
    exp_n   = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue16(16'h000D, 16'h0006, 3'(i), ov_early);
      checks++; if (ov_early !== 1'b0) $display("FAIL basic_latency_early op=%0d got=%b exp=0", i, ov_early); else passed++;
      checks++; if (bus16.out_valid !== 1'b1) $display("FAIL basic_out_valid op=%0d got=%b exp=1", i, bus16.out_valid); else passed++;
      checks++; if (bus16.out !== exp_out[i]) $display("FAIL basic_out op=%0d got=%h exp=%h", i, bus16.out, exp_out[i]); else passed++;
      checks++; if ({bus16.Z, bus16.N, bus16.V} !== {1'b0, exp_n[i], 1'b0})
        $display("FAIL basic_flags op=%0d got=%b exp=%b", i, {bus16.Z, bus16.N, bus16.V}, {1'b0, exp_n[i], 1'b0}); else passed++;
    end
    step();
  endtask

  task automatic test_flags();
    logic [15:0] a   [3];
    logic [15:0] b   [3];
    logic [2:0]  op  [3];
    logic [15:0] eo  [3];
    logic [2:0]  ezv [3];
    logic        ov_early;
    a   = '{16'h0000, 16'h7FFF, 16'h8000};
    b   = '{16'hFFFF, 16'h0001, 16'h0001};
    op  = '{3'b011, 3'b000, 3'b001};
    eo  = '{16'h0000, 16'h8000, 16'h7FFF};
    ezv = '{3'b100, 3'b011, 3'b001};
    for (int i = 0; i < 3; i++) begin
      issue16(a[i], b[i], op[i], ov_early);
      checks++; if (bus16.out !== eo[i]) $display("FAIL flags_out case=%0d got=%h exp=%h", i, bus16.out, eo[i]); else passed++;
      checks++; if ({bus16.Z, bus16.N, bus16.V} !== ezv[i])
        $display("FAIL flags_znv case=%0d got=%b exp=%b", i, {bus16.Z, bus16.N, bus16.V}, ezv[i]); else passed++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit          pat [4];
    int          sent = 0;
    int          received = 0;
    bit          stalled_prev = 1'b0;
    logic [15:0] prev_out = '0;
    logic        exp_ready;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus16.Bin   = 16'h0100;
    bus16.ALUop = 3'b000;
    for (int cyc = 0; cyc < 60 && received < 8; cyc++) begin
      bus16.out_ready = pat[cyc % 4];
      bus16.in_valid  = (sent < 8);
      bus16.Ain       = 16'h0010 + 16'(sent);
      #1;
      exp_ready = !((sent - received) == 2 && !bus16.out_ready);
      checks++; if (bus16.in_ready !== exp_ready)
        $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, bus16.in_ready, exp_ready); else passed++;
      if (stalled_prev) begin
        checks++; if (bus16.out_valid !== 1'b1 || bus16.out !== prev_out)
          $display("FAIL b2b_stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, bus16.out_valid, bus16.out, prev_out); else passed++;
      end
      if (bus16.out_valid && bus16.out_ready) begin
        checks++; if (bus16.out !== 16'h0110 + 16'(received))
          $display("FAIL b2b_order idx=%0d got=%h exp=%h", received, bus16.out, 16'h0110 + 16'(received)); else passed++;
        received++;
      end
      stalled_prev = bus16.out_valid && !bus16.out_ready;
      prev_out     = bus16.out;
      if (bus16.in_valid && bus16.in_ready) sent++;
      step();
    end
    bus16.in_valid = 1'b0;
    checks++; if (received != 8) $display("FAIL b2b_count got=%0d exp=8", received); else passed++;
    checks++; if (bus16.out_valid !== 1'b0) $display("FAIL b2b_no_dup got=%b exp=0", bus16.out_valid); else passed++;
  endtask

  task automatic test_status();
    logic ov_early;
    issue16(16'h0000, 16'hFFFF, 3'b011, ov_early);
    step();
    checks++; if (bus16.status !== 3'b100) $display("FAIL status_zero got=%b exp=100", bus16.status); else passed++;
    bus16.out_ready = 1'b0;
    bus16.Ain = 16'h7FFF; bus16.Bin = 16'h0001; bus16.ALUop = 3'b000;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    step();
    step();
    checks++; if (bus16.status !== 3'b100) $display("FAIL status_hold got=%b exp=100", bus16.status); else passed++;
    checks++; if (bus16.out_valid !== 1'b1 || bus16.out !== 16'h8000)
      $display("FAIL status_stalled_out got=%b/%h exp=1/8000", bus16.out_valid, bus16.out); else passed++;
    bus16.out_ready = 1'b1;
    step();
    checks++; if (bus16.status !== 3'b011) $display("FAIL status_update got=%b exp=011", bus16.status); else passed++;
    checks++; if (bus16.out_valid !== 1'b0) $display("FAIL status_drained got=%b exp=0", bus16.out_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    bus16.out_ready = 1'b0;
    bus16.Ain = 16'h1234; bus16.Bin = 16'h0001; bus16.ALUop = 3'b000;
    bus16.in_valid = 1'b1;
    step();
    step();
    bus16.in_valid = 1'b0;
    checks++; if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1)
      $display("FAIL midreset_full got=%b/%b exp=0/1", bus16.in_ready, bus16.out_valid); else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus16.out_valid !== 1'b0) $display("FAIL midreset_out_valid got=%b exp=0", bus16.out_valid); else passed++;
    checks++; if (bus16.out !== 16'h0000) $display("FAIL midreset_out got=%h exp=0000", bus16.out); else passed++;
    checks++; if (bus16.status !== 3'b000) $display("FAIL midreset_status got=%b exp=000", bus16.status); else passed++;
    checks++; if (bus16.in_ready !== 1'b1) $display("FAIL midreset_in_ready got=%b exp=1", bus16.in_ready); else passed++;
    bus16.out_ready = 1'b1;
    step();
    checks++; if (bus16.out_valid !== 1'b0) $display("FAIL midreset_s1_flushed got=%b exp=0", bus16.out_valid); else passed++;
  endtask

  task automatic test_shift();
    logic        ov_early;
    logic [15:0] e_shl, e_shr;
    logic        e_shr_n;
`ifdef ALU_SHIFT_EN
    e_shl = 16'h0030; e_shr = 16'hFFFF; e_shr_n = 1'b1;
`else
    e_shl = 16'h0004; e_shr = 16'h000F; e_shr_n = 1'b0;
`endif
    issue16(16'h0003, 16'h0004, 3'b110, ov_early);
    checks++; if (bus16.out !== e_shl || bus16.V !== 1'b0)
      $display("FAIL shift_110 got=%h/V%b exp=%h/V0", bus16.out, bus16.V, e_shl); else passed++;
    issue16(16'h8000, 16'h000F, 3'b111, ov_early);
    checks++; if (bus16.out !== e_shr || bus16.N !== e_shr_n || bus16.V !== 1'b0)
      $display("FAIL shift_111 got=%h/N%b/V%b exp=%h/N%b/V0", bus16.out, bus16.N, bus16.V, e_shr, e_shr_n); else passed++;
    step();
  endtask

  task automatic test_widths();
    logic [7:0]  e8  [4];
    logic [31:0] e32 [4];
    e8  = '{8'h13, 8'h07, 8'h04, 8'hF9};
    e32 = '{32'h0000_0013, 32'h0000_0007, 32'h0000_0004, 32'hFFFF_FFF9};
    bus8.Ain  = 8'h0D;         bus8.Bin  = 8'h06;
    bus32.Ain = 32'h0000_000D; bus32.Bin = 32'h0000_0006;
    for (int i = 0; i < 4; i++) begin
      bus8.ALUop = 3'(i); bus32.ALUop = 3'(i);
      bus8.in_valid = 1'b1; bus32.in_valid = 1'b1;
      step();
      bus8.in_valid = 1'b0; bus32.in_valid = 1'b0;
      step();
      checks++; if (bus8.out_valid !== 1'b1 || bus8.out !== e8[i] || bus8.Z !== 1'b0)
        $display("FAIL w8_out op=%0d got=%b/%h exp=1/%h", i, bus8.out_valid, bus8.out, e8[i]); else passed++;
      checks++; if (bus32.out_valid !== 1'b1 || bus32.out !== e32[i] || bus32.Z !== 1'b0)
        $display("FAIL w32_out op=%0d got=%b/%h exp=1/%h", i, bus32.out_valid, bus32.out, e32[i]); else passed++;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_flags();
    test_back_to_back();
    test_status();
    test_reset_mid();
    test_shift();
    test_widths();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
